// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: constants shared between the fetch stage and its users.
//   I_LIT          opcode (word bits [6:0]) that marks a literal prefix
//   LIT_MAX_WORDS  maximum literal payload length in 14-bit words
//   ERR_LITLEN     error code for a literal with an out-of-range length
package core_fetch_pkg;
    localparam logic [6:0] I_LIT         = 7'h7F;
    localparam int         LIT_MAX_WORDS = 4;
    localparam logic [1:0] ERR_LITLEN    = 2'd1;
    localparam int         WORD_W        = 14;
    localparam int         PCP_W         = 28;
endpackage

// File: rtl/core_fetch.sv
// core_fetch: instruction fetch / dispatch stage for one CPU7 core.
// Reads a code word at the core's pcp, decodes it as an instruction pair or
// a literal prefix (length n in bits [13:7], n payload words follow,
// little-endian), and hands the result to the core with a one-cycle strobe.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               core selected; gates FSM progress and every strobe
//   pcp, acore_idle  program pointer and idle flag fed back from the core
//   mem_addr/mem_rd_en/mem_data  program memory read port (1-cycle latency)
//   pcp_step_en      ask the core to advance pcp by one word
//   instr/instr_en   instruction pair dispatch
//   push_value/push_en  literal dispatch
//   fetch_err        sticky literal-length error; busy = not in S_WAIT
module core_fetch
    import core_fetch_pkg::*;
#(
    parameter int IDX     = -1,
    parameter int LIT_MAX = LIT_MAX_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [PCP_W-1:0]            pcp,
    input  logic                        acore_idle,
    output logic [PCP_W-1:0]            mem_addr,
    output logic                        mem_rd_en,
    input  logic [WORD_W-1:0]           mem_data,
    output logic                        pcp_step_en,
    output logic [WORD_W-1:0]           instr,
    output logic                        instr_en,
    output logic [WORD_W*LIT_MAX-1:0]   push_value,
    output logic                        push_en,
    output logic                        fetch_err,
    output logic                        busy
);
    localparam int CW = $clog2(LIT_MAX + 1);

    // Elaboration-time sanity: the length field is 7 bits wide.
    if (LIT_MAX < 1 || LIT_MAX > 127 || IDX < -1) begin : g_param_chk
        $error("core_fetch: bad parameters");
    end

    typedef enum logic [2:0] {
        S_WAIT, S_READ, S_DATA, S_LIT_READ, S_LIT_DATA, S_DISPATCH, S_ERROR
    } state_t;

    state_t                      state;
    logic   [CW-1:0]             cnt;
    logic   [CW-1:0]             k;
    logic                        is_push;
    logic   [WORD_W*LIT_MAX-1:0] acc;
    logic   [WORD_W*LIT_MAX-1:0] acc_merged;
    logic   [6:0]                lit_len;

    assign lit_len = mem_data[13:7];

    // Accumulator with the current payload word dropped into slot k.
    always_comb begin
        acc_merged = acc;
        for (int i = 0; i < LIT_MAX; i++) begin
            if (k == CW'(i)) acc_merged[i*WORD_W +: WORD_W] = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            cnt        <= '0;
            k          <= '0;
            is_push    <= 1'b0;
            acc        <= '0;
            instr      <= '0;
            push_value <= '0;
            fetch_err  <= 1'b0;
        end else if (en) begin
            case (state)
                S_WAIT:     if (acore_idle) state <= S_READ;
                S_READ:     state <= S_DATA;
                S_DATA: begin
                    if (mem_data[6:0] != I_LIT) begin
                        instr   <= mem_data;
                        is_push <= 1'b0;
                        state   <= S_DISPATCH;
                    end else if (lit_len != 7'd0 && lit_len <= 7'(LIT_MAX)) begin
                        acc     <= '0;
                        cnt     <= CW'(lit_len);
                        k       <= '0;
                        is_push <= 1'b1;
                        state   <= S_LIT_READ;
                    end else begin
                        fetch_err <= 1'b1;
                        state     <= S_ERROR;
                    end
                end
                S_LIT_READ: state <= S_LIT_DATA;
                S_LIT_DATA: begin
                    acc <= acc_merged;
                    k   <= k + 1'b1;
                    cnt <= cnt - 1'b1;
                    // Publish the literal together with the move to dispatch so
                    // push_value is already valid during the push_en cycle.
                    if (cnt == CW'(1)) begin
                        push_value <= acc_merged;
                        state      <= S_DISPATCH;
                    end else begin
                        state <= S_LIT_READ;
                    end
                end
                S_DISPATCH: state <= S_WAIT;
                S_ERROR:    state <= S_ERROR;
                default:    state <= S_WAIT;
            endcase
        end
    end

    // Strobes are decoded straight from state so that dropping en in any
    // cycle suppresses the strobe and the held state re-issues it later.
    assign mem_addr    = pcp;
    assign mem_rd_en   = en && (state == S_READ || state == S_LIT_READ);
    assign pcp_step_en = mem_rd_en;
    assign instr_en    = en && (state == S_DISPATCH) && !is_push;
    assign push_en     = en && (state == S_DISPATCH) && is_push;
    assign busy        = (state != S_WAIT);
endmodule

// File: tb/tb_core_fetch.sv
module tb_core_fetch;
    import core_fetch_pkg::*;

    typedef struct packed {
        logic        is_push;
        logic [55:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        idle_req = 1'b0;
    logic [27:0] pcp;
    logic        acore_idle;
    logic [27:0] mem_addr;
    logic        mem_rd_en;
    logic [13:0] mem_data;
    logic        pcp_step_en;
    logic [13:0] instr;
    logic        instr_en;
    logic [55:0] push_value;
    logic        push_en;
    logic        fetch_err;
    logic        busy;

    logic [13:0] mem [0:15];
    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          rd_cnt = 0;
    int          step_cnt = 0;
    int          disp_cnt = 0;

    core_fetch #(.IDX(0), .LIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pcp(pcp), .acore_idle(acore_idle),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .pcp_step_en(pcp_step_en), .instr(instr), .instr_en(instr_en),
        .push_value(push_value), .push_en(push_en), .fetch_err(fetch_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model: idle drops during a dispatch strobe; pcp steps on request.
    assign acore_idle = idle_req && !instr_en && !push_en;

    always @(posedge clk) begin
        if (!rst_n)           pcp <= '0;
        else if (pcp_step_en) pcp <= pcp + 28'd1;
    end

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem[mem_addr[3:0]];
    end

    // Scoreboard monitor: every dispatch strobe pops one expectation.
    initial begin
        exp_t        e;
        logic [55:0] got;
        forever begin
            @(posedge clk);
            if (mem_rd_en)   rd_cnt++;
            if (pcp_step_en) step_cnt++;
            if (instr_en || push_en) begin
                disp_cnt++;
                checks++;
                got = push_en ? push_value : {42'd0, instr};
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL dispatch: unexpected strobe instr_en=%0b push_en=%0b value=%h",
                             instr_en, push_en, got);
                end else begin
                    e = q.pop_front();
                    if ((instr_en && push_en) || e.is_push !== push_en || got !== e.val) begin
                        errors++;
                        $display("FAIL dispatch: got push=%0b value=%h, expected push=%0b value=%h",
                                 push_en, got, e.is_push, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 14'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; idle_req = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one fetch: acore_idle high for one sampling edge. Optionally drop
    // en for 4 cycles when the gap_read-th read strobe is seen (those cycles
    // are not counted). lat = cycles from the sampling edge to the strobe.
    task automatic fetch(input int gap_read, output int lat);
        int rd_seen;
        rd_seen = 0;
        lat = -1;
        @(negedge clk);
        idle_req = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            idle_req = 1'b0;
            if (mem_rd_en) begin
                rd_seen++;
                if (gap_read != 0 && rd_seen == gap_read) begin
                    en = 1'b0;
                    repeat (4) @(negedge clk);
                    en = 1'b1;
                end
            end
            if (instr_en || push_en) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_int("reset mem_rd_en", int'(mem_rd_en), 0);
        check_int("reset pcp_step_en", int'(pcp_step_en), 0);
        check_int("reset instr_en", int'(instr_en), 0);
        check_int("reset push_en", int'(push_en), 0);
        check_int("reset fetch_err", int'(fetch_err), 0);
        check_int("reset busy", int'(busy), 0);
        checks++;
        if (instr !== 14'h0 || push_value !== 56'h0) begin
            errors++;
            $display("FAIL reset data: instr=%h push_value=%h, expected 0", instr, push_value);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_instr();
        int lat, s0;
        clear_mem();
        mem[0] = 14'h0203;
        do_reset();
        q.push_back('{1'b0, 56'h0203});
        s0 = step_cnt;
        fetch(0, lat);
        check_int("instr latency", lat, 3);
        check_int("instr steps", step_cnt - s0, 1);
        check_int("instr pcp", int'(pcp), 1);
        repeat (3) @(negedge clk);
        checks++;
        if (instr !== 14'h0203 || instr_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL instr hold: instr=%h instr_en=%0b busy=%0b, expected 0203/0/0",
                     instr, instr_en, busy);
        end
    endtask

    task automatic test_literal2();
        int lat, s0;
        clear_mem();
        mem[0] = {7'd2, I_LIT};
        mem[1] = 14'h0001;
        mem[2] = 14'h0002;
        do_reset();
        q.push_back('{1'b1, 56'h8001});
        s0 = step_cnt;
        fetch(0, lat);
        check_int("lit2 latency", lat, 7);
        check_int("lit2 steps", step_cnt - s0, 3);
        check_int("lit2 pcp", int'(pcp), 3);
    endtask

    task automatic test_busy();
        int lat, r0;
        clear_mem();
        mem[0] = 14'h1234;
        do_reset();
        r0 = rd_cnt;
        repeat (10) @(negedge clk);
        check_int("busy core reads", rd_cnt - r0, 0);
        check_int("busy core busy", int'(busy), 0);
        q.push_back('{1'b0, 56'h1234});
        fetch(0, lat);
        check_int("busy core latency", lat, 3);
        check_int("busy core reads after", rd_cnt - r0, 1);
    endtask

    task automatic test_bad_len(input logic [6:0] n);
        int r0, d0;
        clear_mem();
        mem[0] = {n, I_LIT};
        do_reset();
        r0 = rd_cnt;
        d0 = disp_cnt;
        @(negedge clk);
        idle_req = 1'b1;                       // held high: must be ignored
        @(negedge clk);                        // S_READ
        @(negedge clk);                        // S_DATA
        check_int($sformatf("badlen%0d err before", n), int'(fetch_err), 0);
        @(negedge clk);
        check_int($sformatf("badlen%0d err rise", n), int'(fetch_err), 1);
        repeat (20) @(negedge clk);
        check_int($sformatf("badlen%0d err sticky", n), int'(fetch_err), 1);
        check_int($sformatf("badlen%0d busy", n), int'(busy), 1);
        check_int($sformatf("badlen%0d reads", n), rd_cnt - r0, 1);
        check_int($sformatf("badlen%0d dispatches", n), disp_cnt - d0, 0);
        idle_req = 1'b0;
        do_reset();
        @(negedge clk);
        check_int($sformatf("badlen%0d err cleared", n), int'(fetch_err), 0);
    endtask

    task automatic test_max_lit();
        int lat;
        clear_mem();
        mem[0] = {7'd4, I_LIT};
        mem[1] = 14'h3FFF;
        mem[2] = 14'h0000;
        mem[3] = 14'h2AAA;
        mem[4] = 14'h1555;
        do_reset();
        q.push_back('{1'b1, {14'h1555, 14'h2AAA, 14'h0000, 14'h3FFF}});
        fetch(0, lat);
        check_int("lit4 latency", lat, 11);
        check_int("lit4 pcp", int'(pcp), 5);
    endtask

    task automatic test_gating();
        int lat, s0, r0;
        clear_mem();
        mem[0] = {7'd3, I_LIT};
        mem[1] = 14'h0011;
        mem[2] = 14'h0222;
        mem[3] = 14'h3333;
        do_reset();
        q.push_back('{1'b1, {14'h3333, 14'h0222, 14'h0011}});
        s0 = step_cnt; r0 = rd_cnt;
        fetch(0, lat);
        check_int("lit3 latency", lat, 9);
        check_int("lit3 steps", step_cnt - s0, 4);
        do_reset();
        q.push_back('{1'b1, {14'h3333, 14'h0222, 14'h0011}});
        s0 = step_cnt; r0 = rd_cnt;
        fetch(2, lat);
        check_int("gated latency", lat, 9);
        check_int("gated steps", step_cnt - s0, 4);
        check_int("gated reads", rd_cnt - r0, 4);
        check_int("gated pcp", int'(pcp), 4);
    endtask

    task automatic test_reset_mid();
        int lat, rd_seen;
        bit hit;
        clear_mem();
        mem[0] = {7'd3, I_LIT};
        mem[1] = 14'h0ABC;
        mem[2] = 14'h1DEF;
        mem[3] = 14'h2345;
        do_reset();
        rd_seen = 0;
        hit = 1'b0;
        @(negedge clk);
        idle_req = 1'b1;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            idle_req = 1'b0;
            if (mem_rd_en) rd_seen++;
            if (rd_seen == 2) begin
                @(negedge clk);                // now in S_LIT_DATA
                rst_n = 1'b0;
                hit = 1'b1;
            end
        end
        check_int("midreset reached", int'(hit), 1);
        @(negedge clk);
        checks++;
        if (mem_rd_en || pcp_step_en || instr_en || push_en || busy || push_value !== 56'h0) begin
            errors++;
            $display("FAIL midreset outputs: rd=%0b step=%0b ie=%0b pe=%0b busy=%0b pv=%h, expected all 0",
                     mem_rd_en, pcp_step_en, instr_en, push_en, busy, push_value);
        end
        rst_n = 1'b1;
        q.push_back('{1'b1, {14'h2345, 14'h1DEF, 14'h0ABC}});
        fetch(0, lat);
        check_int("midreset refetch latency", lat, 9);
        check_int("midreset refetch pcp", int'(pcp), 4);
    endtask

    task automatic test_back_to_back();
        int seen, last;
        clear_mem();
        mem[0] = 14'h0A05;
        mem[1] = {7'd1, I_LIT};
        mem[2] = 14'h2BCD;
        mem[3] = 14'h0C06;
        do_reset();
        q.push_back('{1'b0, 56'h0A05});
        q.push_back('{1'b1, 56'h2BCD});
        q.push_back('{1'b0, 56'h0C06});
        seen = 0;
        last = -1;
        @(negedge clk);
        idle_req = 1'b1;
        for (int i = 1; i <= 60 && seen < 3; i++) begin
            @(negedge clk);
            if (instr_en || push_en) begin
                seen++;
                if (seen == 3) begin
                    idle_req = 1'b0;
                    last = i;
                end
            end
        end
        idle_req = 1'b0;
        // 3 for the pair, then WAIT+5 for the 1-word literal, WAIT+3 for the pair.
        check_int("b2b third dispatch cycle", last, 13);
        repeat (3) @(negedge clk);
        check_int("b2b pcp", int'(pcp), 4);
        check_int("b2b busy after", int'(busy), 0);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_instr();
        test_literal2();
        test_busy();
        test_bad_len(7'd0);
        test_bad_len(7'd5);
        test_max_lit();
        test_gating();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        check_int("scoreboard drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
